// File: rtl/hack_boot_sequencer.sv
// rtl/hack_boot_sequencer.sv - Hack SoC boot/load sequencer
// Holds the CPU in reset while the host fills instruction ROM, then releases it after a timed hold.
module hack_boot_sequencer #(
  parameter int ROM_ADDR_W = 15,
  parameter int RST_CYCLES = 16
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_n,
  input  logic                  active,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [31:0]           cmd_data,
  output logic                  rom_we,
  output logic [ROM_ADDR_W-1:0] rom_addr,
  output logic [15:0]           rom_wdata,
  output logic                  cpu_rst_n,
  output logic                  running,
  output logic                  err,
  output logic [15:0]           load_count
);

  localparam int CNT_W = (RST_CYCLES < 2) ? 1 : $clog2(RST_CYCLES + 1);

  typedef enum logic [1:0] {
    ST_HALT     = 2'd0,
    ST_RST_WAIT = 2'd1,
    ST_RUN      = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    OP_NOP      = 2'b00,
    OP_SET_ADDR = 2'b01,
    OP_WRITE    = 2'b10,
    OP_CTRL     = 2'b11
  } opcode_t;

  state_t                  state_q;
  logic [CNT_W-1:0]        cnt_q;
  logic [ROM_ADDR_W-1:0]   addr_ptr_q;
  logic [15:0]             load_cnt_q;
  logic                    rom_we_q;
  logic [ROM_ADDR_W-1:0]   rom_addr_q;
  logic [15:0]             rom_wdata_q;
  logic                    cpu_rst_n_q;
  logic                    running_q;
  logic                    err_q;
  logic                    xfer;
  opcode_t                 opcode;
  logic                    unused_cmd_bits;

  assign cmd_ready       = wb_rst_n & active & (state_q != ST_RST_WAIT);
  assign xfer            = cmd_valid & cmd_ready;
  assign opcode          = opcode_t'(cmd_data[31:30]);
  assign unused_cmd_bits = ^cmd_data[29:16];

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_n) begin
      state_q     <= ST_HALT;
      cnt_q       <= '0;
      addr_ptr_q  <= '0;
      load_cnt_q  <= '0;
      rom_we_q    <= 1'b0;
      rom_addr_q  <= '0;
      rom_wdata_q <= '0;
      cpu_rst_n_q <= 1'b0;
      running_q   <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      rom_we_q    <= 1'b0;
      // CPU-facing outputs follow the state one edge later
      cpu_rst_n_q <= (state_q == ST_RUN);
      running_q   <= (state_q == ST_RUN);

      if (!active) begin
        state_q <= ST_HALT;
      end else begin
        if (state_q == ST_RST_WAIT) begin
          if (cnt_q == CNT_W'(1)) begin
            state_q <= ST_RUN;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end

        // xfer never fires in RST_WAIT, so it cannot race the countdown above
        if (xfer) begin
          case (opcode)
            OP_NOP: begin
              err_q <= 1'b0;
            end
            OP_SET_ADDR: begin
              if (state_q == ST_HALT) begin
                addr_ptr_q <= cmd_data[ROM_ADDR_W-1:0];
                load_cnt_q <= '0;
              end else begin
                err_q <= 1'b1;
              end
            end
            OP_WRITE: begin
              if (state_q == ST_HALT) begin
                rom_we_q    <= 1'b1;
                rom_addr_q  <= addr_ptr_q;
                rom_wdata_q <= cmd_data[15:0];
                addr_ptr_q  <= addr_ptr_q + ROM_ADDR_W'(1);
                if (load_cnt_q != 16'hFFFF) begin
                  load_cnt_q <= load_cnt_q + 16'd1;
                end
              end else begin
                err_q <= 1'b1;
              end
            end
            OP_CTRL: begin
              if (cmd_data[0]) begin
                if (state_q == ST_HALT) begin
                  state_q <= ST_RST_WAIT;
                  cnt_q   <= CNT_W'(RST_CYCLES);
                end
              end else begin
                state_q <= ST_HALT;
              end
            end
            default: begin
            end
          endcase
        end
      end
    end
  end

  assign rom_we     = rom_we_q;
  assign rom_addr   = rom_addr_q;
  assign rom_wdata  = rom_wdata_q;
  assign cpu_rst_n  = cpu_rst_n_q;
  assign running    = running_q;
  assign err        = err_q;
  assign load_count = load_cnt_q;

endmodule

// File: tb/tb_hack_boot_sequencer.sv
// tb/tb_hack_boot_sequencer.sv - directed vector bench for hack_boot_sequencer
// Inputs change and outputs are sampled on the falling clock edge.
module tb_hack_boot_sequencer;

  logic        wb_clk_i = 1'b0;
  logic        wb_rst_n;
  logic        active;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] cmd_data;
  logic        rom_we;
  logic [14:0] rom_addr;
  logic [15:0] rom_wdata;
  logic        cpu_rst_n;
  logic        running;
  logic        err;
  logic [15:0] load_count;

  int n_cmp = 0;
  int n_bad = 0;

  hack_boot_sequencer #(.ROM_ADDR_W(15), .RST_CYCLES(16)) dut (
    .wb_clk_i  (wb_clk_i),
    .wb_rst_n  (wb_rst_n),
    .active    (active),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_data  (cmd_data),
    .rom_we    (rom_we),
    .rom_addr  (rom_addr),
    .rom_wdata (rom_wdata),
    .cpu_rst_n (cpu_rst_n),
    .running   (running),
    .err       (err),
    .load_count(load_count)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  typedef struct {
    logic        rst_n;
    logic        act;
    logic        vld;
    logic [31:0] data;
    logic        x_rdy;
    logic        x_we;
    logic [14:0] x_addr;
    logic [15:0] x_wdata;
    logic        x_crst;
    logic        x_run;
    logic        x_err;
    logic [15:0] x_lc;
  } vec_t;

  localparam int NV = 10;
  vec_t vecs [NV];

  function automatic vec_t mk(input logic rst_n, input logic act, input logic vld,
                              input logic [31:0] data, input logic x_rdy, input logic x_we,
                              input logic [14:0] x_addr, input logic [15:0] x_wdata,
                              input logic [15:0] x_lc);
    vec_t v;
    v.rst_n = rst_n;  v.act = act;  v.vld = vld;  v.data = data;
    v.x_rdy = x_rdy;  v.x_we = x_we;  v.x_addr = x_addr;  v.x_wdata = x_wdata;
    v.x_crst = 1'b0;  v.x_run = 1'b0;  v.x_err = 1'b0;  v.x_lc = x_lc;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act_v, input logic [31:0] exp_v);
    n_cmp++;
    if (act_v !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", name, act_v, exp_v);
    end
  endtask

  task automatic drive(input logic r, input logic a, input logic v, input logic [31:0] d);
    wb_rst_n  = r;
    active    = a;
    cmd_valid = v;
    cmd_data  = d;
  endtask

  task automatic cyc();
    @(posedge wb_clk_i);
    @(negedge wb_clk_i);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  n;
    logic seen;

    vecs[0] = mk(1'b0, 1'b1, 1'b1, 32'h8000_1111, 1'b0, 1'b0, 15'h0000, 16'h0000, 16'd0);
    vecs[1] = mk(1'b1, 1'b1, 1'b1, 32'h4000_0010, 1'b1, 1'b0, 15'h0000, 16'h0000, 16'd0);
    vecs[2] = mk(1'b1, 1'b1, 1'b1, 32'h8000_AAAA, 1'b1, 1'b1, 15'h0010, 16'hAAAA, 16'd1);
    vecs[3] = mk(1'b1, 1'b1, 1'b1, 32'h8000_5555, 1'b1, 1'b1, 15'h0011, 16'h5555, 16'd2);
    vecs[4] = mk(1'b1, 1'b1, 1'b1, 32'h8000_1234, 1'b1, 1'b1, 15'h0012, 16'h1234, 16'd3);
    vecs[5] = mk(1'b1, 1'b1, 1'b0, 32'h8000_FFFF, 1'b1, 1'b0, 15'h0012, 16'h1234, 16'd3);
    vecs[6] = mk(1'b1, 1'b1, 1'b1, 32'h4000_7FFF, 1'b1, 1'b0, 15'h0012, 16'h1234, 16'd0);
    vecs[7] = mk(1'b1, 1'b1, 1'b1, 32'h8000_0001, 1'b1, 1'b1, 15'h7FFF, 16'h0001, 16'd1);
    vecs[8] = mk(1'b1, 1'b1, 1'b1, 32'h8000_0002, 1'b1, 1'b1, 15'h0000, 16'h0002, 16'd2);
    vecs[9] = mk(1'b1, 1'b0, 1'b1, 32'h8000_0099, 1'b0, 1'b0, 15'h0000, 16'h0002, 16'd2);

    drive(1'b0, 1'b1, 1'b0, 32'h0);
    @(negedge wb_clk_i);

    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].rst_n, vecs[i].act, vecs[i].vld, vecs[i].data);
      #1;
      check($sformatf("v%0d_ready", i), 32'(cmd_ready), 32'(vecs[i].x_rdy));
      cyc();
      check($sformatf("v%0d_we", i), 32'(rom_we), 32'(vecs[i].x_we));
      check($sformatf("v%0d_addr", i), 32'(rom_addr), 32'(vecs[i].x_addr));
      check($sformatf("v%0d_wdata", i), 32'(rom_wdata), 32'(vecs[i].x_wdata));
      check($sformatf("v%0d_cpu_rst_n", i), 32'(cpu_rst_n), 32'(vecs[i].x_crst));
      check($sformatf("v%0d_running", i), 32'(running), 32'(vecs[i].x_run));
      check($sformatf("v%0d_err", i), 32'(err), 32'(vecs[i].x_err));
      check($sformatf("v%0d_load_count", i), 32'(load_count), 32'(vecs[i].x_lc));
    end

    // Run sequence: 16 cycles of RST_WAIT, cpu_rst_n one edge after RUN.
    drive(1'b1, 1'b1, 1'b1, 32'hC000_0001);
    #1;
    check("run_ready", 32'(cmd_ready), 32'd1);
    cyc();
    cmd_valid = 1'b0;
    n = 0;
    seen = 1'b0;
    while (!cmd_ready && n < 40) begin
      if (cpu_rst_n) seen = 1'b1;
      n++;
      cyc();
    end
    check("run_wait_cycles", 32'(n), 32'd16);
    check("run_early_release", 32'(seen), 32'd0);
    check("run_crst_t16", 32'(cpu_rst_n), 32'd0);
    cyc();
    check("run_crst_t17", 32'(cpu_rst_n), 32'd1);
    check("run_running_t17", 32'(running), 32'd1);

    // Loading commands while running are dropped and flag err.
    drive(1'b1, 1'b1, 1'b1, 32'h8000_BEEF);
    cyc();
    cmd_valid = 1'b0;
    check("runwr_we", 32'(rom_we), 32'd0);
    check("runwr_err", 32'(err), 32'd1);
    check("runwr_addr", 32'(rom_addr), 32'h0000);
    check("runwr_lc", 32'(load_count), 32'd2);
    drive(1'b1, 1'b1, 1'b1, 32'h0000_0000);
    cyc();
    cmd_valid = 1'b0;
    check("nop_clear_err", 32'(err), 32'd0);
    drive(1'b1, 1'b1, 1'b1, 32'h4000_0100);
    cyc();
    cmd_valid = 1'b0;
    check("runsa_err", 32'(err), 32'd1);
    check("runsa_lc", 32'(load_count), 32'd2);
    cyc();
    check("err_sticky", 32'(err), 32'd1);
    drive(1'b1, 1'b1, 1'b1, 32'h0000_0000);
    cyc();
    cmd_valid = 1'b0;
    check("nop_clear_err2", 32'(err), 32'd0);
    drive(1'b1, 1'b1, 1'b1, 32'hC000_0000);
    cyc();
    cmd_valid = 1'b0;
    check("halt_crst_t", 32'(cpu_rst_n), 32'd1);
    cyc();
    check("halt_crst_t1", 32'(cpu_rst_n), 32'd0);
    check("halt_running_t1", 32'(running), 32'd0);

    // active drops 5 cycles into the reset hold.
    drive(1'b1, 1'b1, 1'b1, 32'hC000_0001);
    cyc();
    cmd_valid = 1'b0;
    repeat (4) cyc();
    check("drop_in_wait", 32'(cmd_ready), 32'd0);
    active = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      cyc();
      if (cpu_rst_n || cmd_ready) seen = 1'b1;
    end
    check("drop_no_release", 32'(seen), 32'd0);
    active = 1'b1;
    #1;
    check("drop_halt_ready", 32'(cmd_ready), 32'd1);
    check("drop_lc_kept", 32'(load_count), 32'd2);
    drive(1'b1, 1'b1, 1'b1, 32'h8000_00C3);
    cyc();
    cmd_valid = 1'b0;
    check("drop_ptr_kept", 32'(rom_addr), 32'h0001);
    check("drop_wr_we", 32'(rom_we), 32'd1);
    check("drop_wr_data", 32'(rom_wdata), 32'h00C3);
    check("drop_wr_lc", 32'(load_count), 32'd3);
    check("drop_crst", 32'(cpu_rst_n), 32'd0);

    // Reset in the cycle a WRITE is offered.
    drive(1'b0, 1'b1, 1'b1, 32'h8000_5A5A);
    #1;
    check("rst_ready", 32'(cmd_ready), 32'd0);
    cyc();
    check("rst_we", 32'(rom_we), 32'd0);
    check("rst_addr", 32'(rom_addr), 32'd0);
    check("rst_wdata", 32'(rom_wdata), 32'd0);
    check("rst_lc", 32'(load_count), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_crst", 32'(cpu_rst_n), 32'd0);
    check("rst_running", 32'(running), 32'd0);
    drive(1'b1, 1'b1, 1'b1, 32'h8000_0F0F);
    cyc();
    cmd_valid = 1'b0;
    check("postrst_we", 32'(rom_we), 32'd1);
    check("postrst_addr", 32'(rom_addr), 32'd0);
    check("postrst_lc", 32'(load_count), 32'd1);
    cyc();
    check("postrst_we_drop", 32'(rom_we), 32'd0);
    check("postrst_wdata_hold", 32'(rom_wdata), 32'h0F0F);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/hack_boot_sequencer.md
# hack_boot_sequencer

Boot and load controller for the Hack SoC core. It sits between the host, which issues 32-bit commands from the logic-analyzer bank, and the SoC's instruction-ROM write port and CPU reset. It holds the CPU in reset while the ROM is written, then releases the CPU through a timed reset sequence. It also lets the host halt a running CPU and reload the ROM without touching the rest of the chip.

## Interface
Parameters:
- ROM_ADDR_W, 15: ROM word-address width.
- RST_CYCLES, 16: number of cycles `cpu_rst_n` is held low after a RUN command. Must be at least 1.

Ports:
- `wb_clk_i`  in  1  sole clock.
- `wb_rst_n`  in  1  reset, synchronous, active-low.
- `active`  in  1  design enable. 0 forces HALT.
- `cmd_valid`  in  1  host command valid.
- `cmd_ready`  out  1  sequencer accepts a command this cycle.
- `cmd_data`  in  32  bits [31:30] opcode: 00 NOP, 01 SET_ADDR, 10 WRITE, 11 CTRL. Bits [15:0] are the payload.
- `rom_we`  out  1  one-cycle ROM write strobe.
- `rom_addr`  out  ROM_ADDR_W  ROM write address.
- `rom_wdata`  out  16  ROM write data.
- `cpu_rst_n`  out  1  CPU reset, active-low.
- `running`  out  1  state == RUN.
- `err`  out  1  sticky: a SET_ADDR or WRITE command was accepted outside HALT.
- `load_count`  out  16  WRITEs performed since the last SET_ADDR; saturates at 0xFFFF.

## Operation
- States:
  - HALT (reset state): CPU held in reset; all opcodes are executed.
  - RST_WAIT: timed reset hold.
  - RUN: CPU released.
- Handshake:
  - `cmd_ready` = `wb_rst_n` & `active` & (state != RST_WAIT).
  - A command transfers on a clock edge where `cmd_valid` & `cmd_ready`. The host may hold `cmd_valid` indefinitely.
  - `cmd_data` is sampled only on transfer.
- NOP: no effect, except that it clears `err`.
- SET_ADDR:
  - In HALT: addr_ptr <= `cmd_data`[ROM_ADDR_W-1:0] and `load_count` <= 0.
  - In RUN: dropped and `err` <= 1.
- WRITE:
  - In HALT, on the next edge: `rom_we` = 1, `rom_addr` = addr_ptr, `rom_wdata` = `cmd_data`[15:0].
  - On that same edge addr_ptr increments modulo 2^ROM_ADDR_W (wraps from all-ones to 0) and `load_count` increments, saturating.
  - In RUN: dropped, `rom_we` stays 0, `err` <= 1.
- CTRL:
  - `cmd_data`[0]=1 (RUN): from HALT, go to RST_WAIT and load the counter with RST_CYCLES. In RUN it is a no-op.
  - `cmd_data`[0]=0 (HALT): from any state, go to HALT.
- RST_WAIT: the counter decrements each cycle. When it reaches 1, the next state is RUN.
- `cpu_rst_n` = 1 only in RUN; it is a registered output.
- `active` = 0: the next state is HALT from any state, and any in-flight `cmd_valid` is not accepted. addr_ptr, `load_count` and `err` are retained.
- `err` is cleared only by reset or an accepted NOP.

## Timing
- Reset values:
  - State HALT.
  - `cpu_rst_n` = 0, `rom_we` = 0, `rom_addr` = 0, `rom_wdata` = 0.
  - `running` = 0, `err` = 0, `load_count` = 0, addr_ptr = 0.
  - `cmd_ready` = 0 while `wb_rst_n` = 0.
- Reset asserted mid-operation returns everything to the reset values at the next edge, including mid-RST_WAIT. No partial write is issued.
- WRITE latency: accepted at edge T gives `rom_we` high for exactly the cycle after T. Back-to-back WRITEs give consecutive strobes at consecutive addresses, one per cycle.
- `rom_addr` and `rom_wdata` hold their last values when `rom_we` = 0.
- RUN latency: CTRL RUN accepted at edge T gives RST_WAIT during cycles T+1 through T+RST_CYCLES. `cpu_rst_n` and `running` rise at edge T+RST_CYCLES+1.
- HALT latency: CTRL HALT accepted at edge T drives `cpu_rst_n` and `running` to 0 after edge T+1.
- Simultaneous events:
  - `active` falling in the same cycle as an accepted command: `cmd_ready` is already 0, so nothing transfers.
  - Reset overrides everything else.

## Test plan
- Load after reset: SET_ADDR 0x0010, then WRITE 0xAAAA, 0x5555, 0x1234 back-to-back. Required: `rom_we` pulses on 3 consecutive cycles at `rom_addr` 0x10, 0x11, 0x12 with matching data, `load_count` = 3, `cpu_rst_n` stays 0.
- Wrap: SET_ADDR 0x7FFF, then 2 WRITEs. Required: writes land at addresses 0x7FFF and 0x0000.
- Run sequence (RST_CYCLES=16): CTRL RUN accepted at edge T. Required: `cmd_ready` = 0 for 16 cycles, `cpu_rst_n` rises at T+17, `running` = 1.
- Writes during RUN: WRITE 0xBEEF while running. Required: no `rom_we`, `err` = 1. A following NOP clears `err`. CTRL HALT then gives `cpu_rst_n` = 0 one cycle after acceptance.
- `active` drop mid-RST_WAIT: `active` falls 5 cycles into the wait. Required: state HALT, `cpu_rst_n` never rises, and addr_ptr and `load_count` are unchanged.
- Reset mid-load: assert `wb_rst_n` = 0 in the cycle a WRITE is accepted. Required: no `rom_we` pulse, and all outputs at their reset values.
